fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_ctrl_refill_counter.sv | 43 ++++
 rtl/fetch_ctrl.sv | 149 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch refill controller.
//   LINE_WORDS    : default number of 32-bit words per I-cache line
//   fetch_state_t : controller states
//     RUN     | normal fetch; redirect, miss and load-use handling
//     REFILL  | requesting line words from memory, pipeline frozen
//     INSTALL | one-cycle tag write after the last word arrived
package fetch_pkg;

  localparam int LINE_WORDS = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    REFILL  = 2'd1,
    INSTALL = 2'd2
  } fetch_state_t;

  // Saturating increment used for the miss counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val >= max_val) ? max_val : val + 64'd1;
  endfunction

endpackage

// File: rtl/fetch_ctrl_refill_counter.sv
// Word index counter for a cache-line refill.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : force the index to zero (start of a new refill)
//   en_i     : advance the index by one (a word was accepted)
//   idx_o    : current word index within the line
//   wrap_o   : the last word is being accepted this cycle
module refill_counter #(
  parameter  int LINE_WORDS = 4,
  localparam int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             wrap_o
);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  // LINE_WORDS is a power of two, so the increment wraps to zero on its own.
  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (en_i) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  assign wrap_o = en_i && (idx_q == IDX_W'(LINE_WORDS - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch miss controller: freezes the front end on an I-cache
// miss, refills the line word by word from main memory, installs the tag and
// resumes. Also arbitrates branch redirects and load-use stalls.
//   clk, rst          : clock, synchronous active-high reset
//   PCF               : fetch PC
//   ICacheHit         : hit for PCF
//   PCSrcE            : taken redirect from execute
//   LoadUseHazard     : load-use dependency D/E
//   MemReady          : memory delivers one refill word this cycle
//   MemReq, MemAddr   : refill request and word byte address (registered)
//   RefillEn/Idx      : cache word write strobe and word index
//   StallF/D, FlushD/E: pipeline hold and bubble controls
//   MissCount         : saturating count of completed refills (registered)
module fetch_ctrl #(
  parameter  int LINE_WORDS = fetch_pkg::LINE_WORDS,
  parameter  int CNT_W      = 16,
  localparam int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      PCF,
  input  logic             ICacheHit,
  input  logic             PCSrcE,
  input  logic             LoadUseHazard,
  input  logic             MemReady,
  output logic             MemReq,
  output logic [31:0]      MemAddr,
  output logic             RefillEn,
  output logic [IDX_W-1:0] RefillIdx,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] MissCount
);

  import fetch_pkg::*;

  localparam int OFF_W  = IDX_W + 2;
  localparam int LINE_W = 32 - OFF_W;

  fetch_state_t      state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [CNT_W-1:0]  miss_q, miss_d;

  logic              cnt_clr;
  logic              cnt_en;
  logic [IDX_W-1:0]  cnt_idx;
  logic              cnt_wrap;

  // Byte/word offset bits of PCF are irrelevant to the line address.
  logic unused_pcf;
  assign unused_pcf = ^PCF[OFF_W-1:0];

  refill_counter #(
    .LINE_WORDS (LINE_WORDS)
  ) u_refill_counter (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .idx_o  (cnt_idx),
    .wrap_o (cnt_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      line_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      miss_q  <= miss_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    miss_d    = miss_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    MemReq    = 1'b0;
    RefillEn  = 1'b0;
    RefillIdx = '0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    // Address is straight from the line/index registers; forced to zero
    // while reset is applied so nothing downstream sees a stale request.
    MemAddr   = rst ? 32'd0 : {line_q, cnt_idx, 2'b00};

    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (PCSrcE) begin
            // Wrong-path fetch: a miss here must not start a refill.
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (!ICacheHit) begin
            line_d  = PCF[31:OFF_W];
            cnt_clr = 1'b1;
            state_d = REFILL;
            StallF  = 1'b1;
            StallD  = 1'b1;
            FlushE  = 1'b1;
          end else if (LoadUseHazard) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
        end

        REFILL: begin
          // E holds only bubbles here, so redirects and hazards are ignored.
          MemReq = 1'b1;
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
          if (MemReady) begin
            RefillEn  = 1'b1;
            RefillIdx = cnt_idx;
            cnt_en    = 1'b1;
            if (cnt_wrap) begin
              state_d = INSTALL;
            end
          end
        end

        INSTALL: begin
          StallF  = 1'b1;
          StallD  = 1'b1;
          FlushE  = 1'b1;
          miss_d  = CNT_W'(sat_inc(64'(miss_q), CNT_W));
          state_d = RUN;
        end

        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  assign MissCount = miss_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF;
  logic        ICacheHit, PCSrcE, LoadUseHazard, MemReady;

  logic        MemReq, RefillEn, StallF, StallD, FlushD, FlushE;
  logic [31:0] MemAddr;
  logic [1:0]  RefillIdx;
  logic [15:0] MissCount;

  logic        s_MemReq, s_RefillEn, s_StallF, s_StallD, s_FlushD, s_FlushE;
  logic [31:0] s_MemAddr;
  logic [1:0]  s_RefillIdx;
  logic [1:0]  s_MissCount;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .PCF(PCF), .ICacheHit(ICacheHit), .PCSrcE(PCSrcE),
    .LoadUseHazard(LoadUseHazard), .MemReady(MemReady), .MemReq(MemReq),
    .MemAddr(MemAddr), .RefillEn(RefillEn), .RefillIdx(RefillIdx),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .MissCount(MissCount)
  );

  fetch_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .PCF(PCF), .ICacheHit(ICacheHit), .PCSrcE(PCSrcE),
    .LoadUseHazard(LoadUseHazard), .MemReady(MemReady), .MemReq(s_MemReq),
    .MemAddr(s_MemAddr), .RefillEn(s_RefillEn), .RefillIdx(s_RefillIdx),
    .StallF(s_StallF), .StallD(s_StallD), .FlushD(s_FlushD), .FlushE(s_FlushE),
    .MissCount(s_MissCount)
  );

  // A redirect can only be resolved in RUN; E carries bubbles otherwise.
  always @(negedge clk) begin
    if (rst === 1'b0 && PCSrcE === 1'b1)
      assert (dut.state_q == RUN) else $error("PCSrcE asserted outside RUN");
  end

  // ctrl = {MemReq, RefillEn, StallF, StallD, FlushD, FlushE}
  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_STALL = 6'b001101;
  localparam logic [5:0] C_REF   = 6'b101101;
  localparam logic [5:0] C_REFW  = 6'b111101;
  localparam logic [5:0] C_FLUSH = 6'b000011;

  typedef struct {
    logic        rst;
    logic [31:0] pcf;
    logic        hit, pcsrc, lu, rdy;
    logic [5:0]  ctrl;
    logic [1:0]  idx;
    logic [31:0] addr;
    logic [15:0] miss;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic [31:0] p, input logic h,
                     input logic pc, input logic l, input logic rd,
                     input logic [5:0] c, input logic [1:0] i,
                     input logic [31:0] a, input logic [15:0] m);
    vec_t v;
    v.rst = r; v.pcf = p; v.hit = h; v.pcsrc = pc; v.lu = l; v.rdy = rd;
    v.ctrl = c; v.idx = i; v.addr = a; v.miss = m;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] p, input logic h,
                       input logic pc, input logic l, input logic rd);
    rst = r; PCF = p; ICacheHit = h; PCSrcE = pc; LoadUseHazard = l; MemReady = rd;
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] prev_line;
    vec_t        e;
    int          n_ref, pulses, stalls, ens;
    logic        rdy;
    logic [15:0] miss_before;

    drive(1, 0, 1, 0, 0, 0);
    repeat (2) @(posedge clk);

    // reset cycle
    add(1, 32'h0, 1, 0, 0, 0, C_NONE, 0, 32'h0, 0);
    // reset after two refill words abandons the refill
    add(0, 32'h200, 0, 0, 0, 0, C_STALL, 0, 32'h0,   0);
    add(0, 32'h200, 0, 0, 0, 1, C_REFW,  0, 32'h200, 0);
    add(0, 32'h200, 0, 0, 0, 1, C_REFW,  1, 32'h204, 0);
    add(1, 32'h200, 0, 0, 0, 1, C_NONE,  0, 32'h0,   0);
    add(0, 32'h200, 1, 0, 0, 0, C_NONE,  0, 32'h0,   0);
    // miss at 0x40, back-to-back words
    add(0, 32'h40, 0, 0, 0, 0, C_STALL, 0, 32'h0, 0);
    for (int j = 0; j < 4; j++)
      add(0, 32'h40, 0, 0, 0, 1, C_REFW, 2'(j), 32'h40 + 32'(4 * j), 0);
    add(0, 32'h40, 0, 0, 0, 0, C_STALL, 0, 32'h40, 0);
    add(0, 32'h40, 1, 0, 0, 0, C_NONE,  0, 32'h40, 1);
    // miss at 0x100, gapped MemReady 1,0,0,1,1,0,1; hazards ignored meanwhile
    add(0, 32'h100, 0, 0, 0, 0, C_STALL, 0, 32'h40,  1);
    add(0, 32'h100, 0, 0, 0, 1, C_REFW,  0, 32'h100, 1);
    add(0, 32'h100, 0, 0, 1, 0, C_REF,   0, 32'h104, 1);
    add(0, 32'h100, 0, 0, 0, 0, C_REF,   0, 32'h104, 1);
    add(0, 32'h100, 0, 0, 0, 1, C_REFW,  1, 32'h104, 1);
    add(0, 32'h100, 0, 0, 0, 1, C_REFW,  2, 32'h108, 1);
    add(0, 32'h100, 0, 0, 1, 0, C_REF,   0, 32'h10C, 1);
    add(0, 32'h100, 0, 0, 0, 1, C_REFW,  3, 32'h10C, 1);
    add(0, 32'h100, 1, 0, 1, 0, C_STALL, 0, 32'h100, 1);
    add(0, 32'h100, 1, 0, 0, 0, C_NONE,  0, 32'h100, 2);
    // redirect beats miss and hazard; single-cycle load-use stall
    add(0, 32'h300, 0, 1, 0, 0, C_FLUSH, 0, 32'h100, 2);
    add(0, 32'h180, 1, 1, 1, 0, C_FLUSH, 0, 32'h100, 2);
    add(0, 32'h180, 1, 0, 1, 0, C_STALL, 0, 32'h100, 2);
    add(0, 32'h180, 1, 0, 0, 0, C_NONE,  0, 32'h100, 2);
    // reset, then five back-to-back misses (miss beats load-use on k=2)
    add(1, 32'h180, 1, 0, 0, 0, C_NONE, 0, 32'h0, 2);
    prev_line = 32'h0;
    for (int k = 0; k < 5; k++) begin
      pc = 32'h1000 + 32'(16 * k);
      add(0, pc, 0, 0, (k == 2), 0, C_STALL, 0, prev_line, 16'(k));
      for (int j = 0; j < 4; j++)
        add(0, pc, 0, 0, 0, 1, C_REFW, 2'(j), pc + 32'(4 * j), 16'(k));
      add(0, pc, 1, 0, 0, 0, C_STALL, 0, pc, 16'(k));
      prev_line = pc;
    end
    add(0, 32'h1040, 1, 0, 0, 0, C_NONE, 0, 32'h1040, 5);

    foreach (vecs[n]) begin
      @(posedge clk); #1;
      drive(vecs[n].rst, vecs[n].pcf, vecs[n].hit, vecs[n].pcsrc, vecs[n].lu, vecs[n].rdy);
      exp_q.push_back(vecs[n]);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("vec%0d ctrl", n),
            {26'd0, MemReq, RefillEn, StallF, StallD, FlushD, FlushE}, {26'd0, e.ctrl});
      check($sformatf("vec%0d idx", n), {30'd0, RefillIdx}, {30'd0, e.idx});
      check($sformatf("vec%0d addr", n), MemAddr, e.addr);
      check($sformatf("vec%0d miss", n), {16'd0, MissCount}, {16'd0, e.miss});
      check($sformatf("vec%0d sat_miss", n), {30'd0, s_MissCount},
            (e.miss > 16'd3) ? 32'd3 : {16'd0, e.miss});
    end

    // Random MemReady gaps: stall length must be 1 + refill cycles + 1.
    miss_before = MissCount;
    n_ref = 0; pulses = 0; stalls = 0; ens = 0;
    @(posedge clk); #1;
    drive(0, 32'h500, 0, 0, 0, 0);
    @(negedge clk);
    stalls += int'(StallF);
    while (pulses < 4 && n_ref < 200) begin
      @(posedge clk); #1;
      rdy = (n_ref >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
      drive(0, 32'h500, 0, 0, 0, rdy);
      if (rdy) pulses++;
      n_ref++;
      @(negedge clk);
      stalls += int'(StallF);
      ens    += int'(RefillEn);
    end
    check("rand refill bound", 32'(pulses), 32'd4);
    @(posedge clk); #1;
    drive(0, 32'h500, 1, 0, 0, 0);
    @(negedge clk);
    stalls += int'(StallF);
    check("rand install memreq", {31'd0, MemReq}, 32'd0);
    @(posedge clk); #1;
    drive(0, 32'h500, 1, 0, 0, 0);
    @(negedge clk);
    check("rand resume stall", {31'd0, StallF}, 32'd0);
    check("rand refill pulses", 32'(ens), 32'd4);
    check("rand stall cycles", 32'(stalls), 32'(n_ref + 2));
    check("rand misscount", {16'd0, MissCount}, {16'd0, miss_before + 16'd1});
    check("rand sat misscount", {30'd0, s_MissCount}, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
